// File: rtl/sha1_pkg.sv
// Shared register map, status bits and sequencer encodings for the
// SHA-1 Wishbone slave and its bus sequencer.
package sha1_pkg;

    localparam logic [31:0] OFS_ID     = 32'h0000_0000;
    localparam logic [31:0] OFS_PANIC  = 32'h0000_0004;
    localparam logic [31:0] OFS_OPS    = 32'h0000_0008;
    localparam logic [31:0] OFS_MSG_IN = 32'h0000_000C;
    localparam logic [31:0] OFS_DIGEST = 32'h0000_0010;

    localparam int OPS_ON    = 0;
    localparam int OPS_RESET = 1;
    localparam int OPS_PANIC = 2;
    localparam int OPS_DONE  = 3;

    localparam logic [31:0] EBUSY  = 32'hffff_fff0;
    localparam logic [31:0] EINVAL = 32'hffff_ffea;
    localparam logic [31:0] ACK    = 32'h0000_0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_WR,
        S_LOAD,
        S_POLL,
        S_DIG,
        S_OUT,
        S_ERROR
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ACK   = 2'd1,
        ERR_PANIC = 2'd2,
        ERR_POLL  = 2'd3
    } err_code_t;

endpackage

// File: rtl/sha1_wb_master_port.sv
// Single-transaction Wishbone master: holds cyc/stb until ack, always
// leaves one idle cycle after, and gives up after ACK_LIMIT cycles.
module sha1_wb_master_port #(
    parameter int ACK_LIMIT = 15
) (
    input  logic        wb_clk_i,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdat,
    output logic        done,
    output logic [31:0] rdat,
    output logic        timeout,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i
);

    localparam int CW = $clog2(ACK_LIMIT + 1);

    logic [CW-1:0] ack_cnt;

    // cyc is dropped at the edge after ack, so a request seen in the
    // following cycle starts no earlier than one idle cycle later.
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_sel_o <= 4'h0;
            m_adr_o <= '0;
            m_dat_o <= '0;
            ack_cnt <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
            rdat    <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (m_cyc_o) begin
                if (m_ack_i) begin
                    m_cyc_o <= 1'b0;
                    m_stb_o <= 1'b0;
                    m_we_o  <= 1'b0;
                    m_sel_o <= 4'h0;
                    done    <= 1'b1;
                    rdat    <= m_dat_i;
                end else if (ack_cnt == CW'(ACK_LIMIT - 1)) begin
                    m_cyc_o <= 1'b0;
                    m_stb_o <= 1'b0;
                    m_we_o  <= 1'b0;
                    m_sel_o <= 4'h0;
                    timeout <= 1'b1;
                end else begin
                    ack_cnt <= ack_cnt + 1'b1;
                end
            end else if (req) begin
                m_cyc_o <= 1'b1;
                m_stb_o <= 1'b1;
                m_we_o  <= we;
                m_sel_o <= 4'hF;
                m_adr_o <= adr;
                m_dat_o <= wdat;
                ack_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sha1_wb_sequencer.sv
// Runs one SHA-1 block on the slave: reset, 16 message writes, status
// polling, 5 digest reads, then presents the 160-bit digest.
module sha1_wb_sequencer
    import sha1_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0024,
    parameter int          POLL_GAP     = 4,
    parameter int          POLL_LIMIT   = 1023,
    parameter int          ACK_LIMIT    = 15
) (
    input  logic         wb_clk_i,
    input  logic         reset,
    input  logic         start,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [31:0]  msg_data,
    output logic         digest_valid,
    output logic [159:0] digest,
    output logic         busy,
    output logic         error,
    output logic [1:0]   err_code,
    input  logic         err_clr,
    output logic         m_cyc_o,
    output logic         m_stb_o,
    output logic         m_we_o,
    output logic [3:0]   m_sel_o,
    output logic [31:0]  m_adr_o,
    output logic [31:0]  m_dat_o,
    input  logic         m_ack_i,
    input  logic [31:0]  m_dat_i
);

    localparam int GW = $clog2(POLL_GAP + 1);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    localparam logic [31:0] ADR_OPS = BASE_ADDRESS + OFS_OPS;
    localparam logic [31:0] ADR_MSG = BASE_ADDRESS + OFS_MSG_IN;
    localparam logic [31:0] ADR_DIG = BASE_ADDRESS + OFS_DIGEST;

    seq_state_t    state, state_d;
    err_code_t     err_q, err_d;
    logic          in_flight, in_flight_d;
    logic [3:0]    word_cnt;
    logic [2:0]    dig_cnt;
    logic [GW-1:0] gap_cnt;
    logic [PW-1:0] poll_cnt;

    logic          req, req_we;
    logic [31:0]   req_adr, req_wdat;
    logic          mp_done, mp_timeout;
    logic [31:0]   mp_rdat;

    sha1_wb_master_port #(
        .ACK_LIMIT(ACK_LIMIT)
    ) u_port (
        .wb_clk_i(wb_clk_i),
        .reset   (reset),
        .req     (req),
        .we      (req_we),
        .adr     (req_adr),
        .wdat    (req_wdat),
        .done    (mp_done),
        .rdat    (mp_rdat),
        .timeout (mp_timeout),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_sel_o (m_sel_o),
        .m_adr_o (m_adr_o),
        .m_dat_o (m_dat_o),
        .m_ack_i (m_ack_i),
        .m_dat_i (m_dat_i)
    );

    always_comb begin
        state_d  = state;
        err_d    = err_q;
        req      = 1'b0;
        req_we   = 1'b0;
        req_adr  = ADR_OPS;
        req_wdat = '0;
        unique case (state)
            S_IDLE: if (start) state_d = S_RST_WR;
            S_RST_WR: begin
                if (mp_done) begin
                    state_d = S_LOAD;
                end else if (!in_flight) begin
                    req      = 1'b1;
                    req_we   = 1'b1;
                    req_wdat = 32'd1 << OPS_RESET;
                end
            end
            S_LOAD: begin
                if (mp_done && word_cnt == 4'd15) state_d = S_POLL;
                if (msg_valid && msg_ready) begin
                    req      = 1'b1;
                    req_we   = 1'b1;
                    req_adr  = ADR_MSG;
                    req_wdat = msg_data;
                end
            end
            S_POLL: begin
                if (mp_done) begin
                    if (mp_rdat[OPS_PANIC]) begin
                        state_d = S_ERROR;
                        err_d   = ERR_PANIC;
                    end else if (mp_rdat[OPS_DONE]) begin
                        state_d = S_DIG;
                    end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
                        state_d = S_ERROR;
                        err_d   = ERR_POLL;
                    end
                end else if (!in_flight && gap_cnt == GW'(POLL_GAP)) begin
                    req = 1'b1;
                end
            end
            S_DIG: begin
                // the next read is issued in the done cycle itself
                if (mp_done && mp_rdat == EBUSY) begin
                    state_d = S_ERROR;
                    err_d   = ERR_PANIC;
                end else if (mp_done && dig_cnt == 3'd4) begin
                    state_d = S_OUT;
                end else if (mp_done || !in_flight) begin
                    req     = 1'b1;
                    req_adr = ADR_DIG;
                end
            end
            S_OUT: state_d = S_IDLE;
            S_ERROR: begin
                if (err_clr) begin
                    state_d = S_IDLE;
                    err_d   = ERR_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (mp_timeout) begin
            state_d = S_ERROR;
            err_d   = ERR_ACK;
            req     = 1'b0;
        end
    end

    assign in_flight_d = req | (in_flight & ~mp_done & ~mp_timeout);
    assign err_code    = err_q;

    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            state        <= S_IDLE;
            err_q        <= ERR_NONE;
            in_flight    <= 1'b0;
            word_cnt     <= '0;
            dig_cnt      <= '0;
            gap_cnt      <= '0;
            poll_cnt     <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            msg_ready    <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_d;
            err_q        <= err_d;
            in_flight    <= in_flight_d;
            msg_ready    <= (state_d == S_LOAD) && !in_flight_d;
            busy         <= (state_d != S_IDLE) && (state_d != S_ERROR);
            error        <= (state_d == S_ERROR);
            // lags OUT by one cycle so it coincides with busy falling
            digest_valid <= (state == S_OUT);
            if (state == S_IDLE && start) begin
                digest   <= '0;
                word_cnt <= '0;
                dig_cnt  <= '0;
                poll_cnt <= '0;
            end
            if (state == S_LOAD && mp_done) word_cnt <= word_cnt + 4'd1;
            if (state == S_POLL && mp_done) poll_cnt <= poll_cnt + 1'b1;
            if (state == S_DIG && mp_done) begin
                digest[{dig_cnt, 5'd0} +: 32] <= mp_rdat;
                dig_cnt <= dig_cnt + 3'd1;
            end
            if (state != S_POLL || mp_done || req) begin
                gap_cnt <= '0;
            end else if (!in_flight && gap_cnt != GW'(POLL_GAP)) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sha1_wb_sequencer.sv
// Directed bench for sha1_wb_sequencer with a behavioural SHA-1 slave
// and a Wishbone protocol monitor.
module tb_sha1_wb_sequencer;

    localparam logic [31:0] A_OPS = 32'h3000_002C;
    localparam logic [31:0] A_MSG = 32'h3000_0030;
    localparam logic [31:0] A_DIG = 32'h3000_0034;
    localparam logic [159:0] ABC =
        160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

    logic         wb_clk_i = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         msg_valid = 1'b0;
    logic         msg_ready;
    logic [31:0]  msg_data = '0;
    logic         digest_valid;
    logic [159:0] digest;
    logic         busy, error;
    logic [1:0]   err_code;
    logic         err_clr = 1'b0;
    logic         m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]   m_sel_o;
    logic [31:0]  m_adr_o, m_dat_o;
    logic         m_ack_i;
    logic [31:0]  m_dat_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    sha1_wb_sequencer dut (
        .wb_clk_i    (wb_clk_i),
        .reset       (reset),
        .start       (start),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .msg_data    (msg_data),
        .digest_valid(digest_valid),
        .digest      (digest),
        .busy        (busy),
        .error       (error),
        .err_code    (err_code),
        .err_clr     (err_clr),
        .m_cyc_o     (m_cyc_o),
        .m_stb_o     (m_stb_o),
        .m_we_o      (m_we_o),
        .m_sel_o     (m_sel_o),
        .m_adr_o     (m_adr_o),
        .m_dat_o     (m_dat_o),
        .m_ack_i     (m_ack_i),
        .m_dat_i     (m_dat_i)
    );

    task automatic chk(input string tag, input logic [159:0] got,
                       input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // behavioural slave: registered ack, computes SHA-1 after 16 words
    logic [31:0]  s_w [16];
    int           s_wcnt = 0;
    int           s_dcnt = 0;
    int           s_busy = 0;
    logic         s_done = 1'b0;
    logic         s_ack = 1'b0;
    logic [31:0]  s_rdat = '0;
    logic [159:0] s_h = '0;
    logic         f_noack = 1'b0;
    logic         f_panic = 1'b0;

    assign m_ack_i = s_ack;
    assign m_dat_i = s_rdat;

    function automatic logic [159:0] sha1_blk();
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp, x;
        for (int t = 0; t < 16; t++) w[t] = s_w[t];
        for (int t = 16; t < 80; t++) begin
            x = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = {x[30:0], x[31]};
        end
        a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE;
        d = 32'h10325476; e = 32'hC3D2E1F0;
        for (int t = 0; t < 80; t++) begin
            if (t < 20) begin
                f = (b & c) | (~b & d); k = 32'h5A827999;
            end else if (t < 40) begin
                f = b ^ c ^ d; k = 32'h6ED9EBA1;
            end else if (t < 60) begin
                f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC;
            end else begin
                f = b ^ c ^ d; k = 32'hCA62C1D6;
            end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {a + 32'h67452301, b + 32'hEFCDAB89, c + 32'h98BADCFE,
                d + 32'h10325476, e + 32'hC3D2E1F0};
    endfunction

    always @(posedge wb_clk_i) begin
        s_ack <= 1'b0;
        if (s_busy != 0) begin
            s_busy <= s_busy - 1;
            if (s_busy == 1) begin
                s_done <= 1'b1;
                s_h    <= sha1_blk();
            end
        end
        if (m_cyc_o && m_stb_o && !s_ack &&
            !(f_noack && m_we_o && m_adr_o == A_MSG && s_wcnt == 2)) begin
            s_ack  <= 1'b1;
            s_rdat <= '0;
            if (m_we_o) begin
                if (m_adr_o == A_OPS && m_dat_o[1]) begin
                    s_wcnt <= 0; s_dcnt <= 0; s_busy <= 0; s_done <= 1'b0;
                end else if (m_adr_o == A_MSG && s_wcnt < 16) begin
                    s_w[s_wcnt] <= m_dat_o;
                    s_wcnt <= s_wcnt + 1;
                    if (s_wcnt == 15) s_busy <= 20;
                end
            end else if (m_adr_o == A_OPS) begin
                s_rdat <= f_panic ? 32'h4 : {28'd0, s_done, 3'd0};
            end else if (m_adr_o == A_DIG && s_dcnt < 5) begin
                s_rdat <= s_h[32*s_dcnt +: 32];
                s_dcnt <= s_dcnt + 1;
            end
        end
    end

    // protocol monitor, sampled mid-cycle
    int   txn_cnt = 0, ops_rd = 0, dig_rd = 0, dv_cnt = 0;
    int   viol = 0, drop_cnt = 0, run_len = 0, last_len = 0;
    logic p_stb = 1'b0, p_ack = 1'b0;
    logic [31:0] p_adr = '0;

    always @(negedge wb_clk_i) begin
        if (digest_valid) dv_cnt++;
        if (m_stb_o && !p_stb) begin
            txn_cnt++;
            if (m_adr_o == A_OPS && !m_we_o) ops_rd++;
            if (m_adr_o == A_DIG) dig_rd++;
        end
        if (p_stb && p_ack && m_stb_o) viol++;
        if (p_stb && !p_ack && m_stb_o && m_adr_o != p_adr) viol++;
        if (p_stb && !p_ack && !m_stb_o && !reset) drop_cnt++;
        if (m_stb_o && (m_sel_o != 4'hF || !m_cyc_o)) viol++;
        if (m_stb_o) run_len++;
        else begin
            if (p_stb) last_len = run_len;
            run_len = 0;
        end
        p_stb = m_stb_o; p_ack = m_ack_i; p_adr = m_adr_o;
    end

    logic [31:0] msg [16];

    task automatic pulse_start();
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
    endtask

    task automatic feed(input int stall_at, input bit spam, output bit ok);
        int t;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == stall_at) begin
                msg_valid = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    start = spam && (k % 4 == 1);
                    @(negedge wb_clk_i);
                end
                start = 1'b0;
            end
            msg_valid = 1'b1;
            msg_data  = msg[i];
            t = 0;
            while (!msg_ready && t < 200) begin
                @(negedge wb_clk_i);
                t++;
            end
            if (t >= 200) begin
                ok = 1'b0;
                msg_valid = 1'b0;
                return;
            end
            @(negedge wb_clk_i);
        end
        msg_valid = 1'b0;
    endtask

    task automatic run_abc(input int stall_at, input bit spam);
        int t0, o0, d0, v0, t, bad;
        bit ok;
        t0 = txn_cnt; o0 = ops_rd; d0 = dig_rd; v0 = dv_cnt;
        pulse_start();
        feed(stall_at, spam, ok);
        chk("feed_ok", ok, 1);
        t = 0;
        while (!digest_valid && t < 3000) begin
            @(negedge wb_clk_i);
            t++;
        end
        chk("dv_seen", digest_valid, 1);
        chk("digest", digest, ABC);
        chk("busy_at_dv", busy, 0);
        @(negedge wb_clk_i);
        chk("dv_pulse", digest_valid, 0);
        @(negedge wb_clk_i);
        chk("dv_count", dv_cnt - v0, 1);
        chk("dig_reads", dig_rd - d0, 5);
        chk("txn_count", txn_cnt - t0, 22 + (ops_rd - o0));
        chk("slave_words", s_wcnt, 16);
        bad = 0;
        for (int i = 0; i < 16; i++) if (s_w[i] !== msg[i]) bad++;
        chk("msg_words", bad, 0);
        chk("protocol", viol, 0);
    endtask

    initial begin
        int t, d0, v0, o0;
        bit ok;
        for (int i = 0; i < 16; i++) msg[i] = '0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;

        repeat (3) @(negedge wb_clk_i);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_code", err_code, 0);
        chk("rst_dv", digest_valid, 0);
        chk("rst_digest", digest, 0);
        chk("rst_cyc", {m_cyc_o, m_stb_o, msg_ready}, 0);
        reset = 1'b0;
        @(negedge wb_clk_i);

        run_abc(-1, 1'b0);

        f_noack = 1'b1;
        d0 = drop_cnt;
        pulse_start();
        feed(-1, 1'b0, ok);
        chk("noack_feed_blocked", ok, 0);
        chk("noack_error", error, 1);
        chk("noack_code", err_code, 1);
        chk("noack_bus", m_cyc_o, 0);
        chk("noack_busy", busy, 0);
        chk("noack_drop", drop_cnt - d0, 1);
        chk("noack_len", last_len, 15);
        f_noack = 1'b0;
        err_clr = 1'b1;
        start   = 1'b1;
        @(negedge wb_clk_i);
        err_clr = 1'b0;
        start   = 1'b0;
        @(negedge wb_clk_i);
        chk("clr_error", error, 0);
        chk("clr_code", err_code, 0);
        chk("clr_busy", busy, 0);
        run_abc(-1, 1'b0);

        f_panic = 1'b1;
        d0 = dig_rd;
        pulse_start();
        feed(-1, 1'b0, ok);
        chk("panic_feed", ok, 1);
        t = 0;
        while (!error && t < 3000) begin
            @(negedge wb_clk_i);
            t++;
        end
        chk("panic_error", error, 1);
        chk("panic_code", err_code, 2);
        repeat (2) @(negedge wb_clk_i);
        chk("panic_no_dig", dig_rd - d0, 0);
        f_panic = 1'b0;
        err_clr = 1'b1;
        @(negedge wb_clk_i);
        err_clr = 1'b0;
        @(negedge wb_clk_i);

        o0 = ops_rd;
        v0 = dv_cnt;
        pulse_start();
        feed(-1, 1'b0, ok);
        t = 0;
        while (ops_rd == o0 && t < 3000) begin
            @(negedge wb_clk_i);
            t++;
        end
        chk("poll_reached", ops_rd > o0, 1);
        reset = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        reset = 1'b0;
        repeat (60) @(negedge wb_clk_i);
        chk("rst_no_dv", dv_cnt - v0, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cyc", m_cyc_o, 0);
        chk("rst_mid_digest", digest, 0);
        run_abc(-1, 1'b0);

        run_abc(7, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
